configurable_mode_fifo: RTL
===========================

// Module: configurable_mode_fifo
// PURPOSE
//  Synchronous single-clock FIFO with selectable read mode (registered or first-word-fall-through).
//  Runtime-programmable almost-full/almost-empty thresholds, occupancy count output,
//  synchronous flush, and sticky overflow/underflow error flags.
//  Generic buffering element between streaming datapath stages in the fifo library.
// PARAMETERS
//  DATA_WIDTH  8   width of wr_data/rd_data
//  DEPTH       16  number of entries; power of two, >=2
//  ADDR_WIDTH  $clog2(DEPTH)  memory address width; CW = ADDR_WIDTH+1 is the count width
//  FWFT        0   0: registered read; 1: first-word-fall-through
// PORTS
//  clk           in   1           clock, rising edge
//  rst_n         in   1           asynchronous active-low reset
//  flush         in   1           synchronous clear of contents and error flags
//  wr_en         in   1           write request
//  wr_data       in   DATA_WIDTH  write data
//  rd_en         in   1           read (pop) request
//  rd_data       out  DATA_WIDTH  read data
//  rd_valid      out  1           rd_data qualifier
//  af_thresh     in   CW          almost_full threshold
//  ae_thresh     in   CW          almost_empty threshold
//  count         out  CW          current occupancy, 0..DEPTH
//  full          out  1           count==DEPTH
//  empty         out  1           count==0
//  almost_full   out  1           count>=af_thresh
//  almost_empty  out  1           count<=ae_thresh
//  overflow      out  1           sticky: write attempted while full
//  underflow     out  1           sticky: read attempted while empty
// BEHAVIOUR
//  - Accept rules: wr_acc = wr_en & ~full & ~flush; rd_acc = rd_en & ~empty & ~flush.
//    Full is evaluated before the same-cycle read, so a write while full is rejected even if rd_en=1.
//  - State: wr_ptr/rd_ptr are ADDR_WIDTH bits and wrap DEPTH-1 -> 0. count is a register (CW bits).
//    count_next = count + wr_acc - rd_acc. Simultaneous wr_acc and rd_acc leave count unchanged.
//  - Flag decode: full, empty, almost_full and almost_empty are combinational decodes of the registered count.
//    Threshold inputs are sampled live. af_thresh=0 forces almost_full=1; ae_thresh>=DEPTH forces almost_empty=1.
//  - Read, FWFT=0: on rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1 in the next cycle (latency 1).
//    Otherwise rd_valid <= 0 and rd_data holds its last value.
//  - Read, FWFT=1: rd_data = mem[rd_ptr] combinationally and rd_valid = ~empty.
//    rd_en acts as the pop/ack. A word written into an empty FIFO is visible the cycle after the write.
//  - Memory: mem[wr_ptr] <= wr_data on wr_acc. Memory has no reset.
//    Reading and writing the same address in one cycle returns the old contents.
//    This cannot happen while empty, because empty blocks the read.
//  - Errors: overflow <= 1 when wr_en & full & ~flush; underflow <= 1 when rd_en & empty & ~flush.
//    Both hold until flush or reset. Errors never alter pointers, count or memory.
//  - flush=1 (synchronous, overrides wr_en/rd_en): pointers and count <= 0; rd_valid, overflow, underflow <= 0.
//    rd_data (FWFT=0) holds. Memory contents are not cleared.
//  - Reset (async assert, sync-released externally): pointers, count, rd_data, rd_valid, overflow, underflow = 0.
//    Hence empty=1, full=0, almost_full=(af_thresh==0), almost_empty=1.
//    Reset mid-transfer discards everything; no partial write completes.
// TESTING
//  1 Reset, FWFT=0, af=14, ae=2: empty=1, full=0, count=0, almost_empty=1, almost_full=0, rd_valid=0.
//  2 Write 0x01..0x10 (16 cycles), then read 16 -> full=1 at count=16; rd_data 0x01..0x10 in order,
//    each rd_valid one cycle after rd_en; empty=1 at the end.
//  3 Fill to 16, then wr_en=1 rd_en=1 for 1 cycle -> write rejected, overflow=1, count=15.
//    Then rd_en on an empty FIFO -> underflow=1. Then flush -> both flags 0, count=0.
//  4 Count at 8, wr_en=rd_en=1 for 40 cycles (pointers wrap twice) -> count stays 8, data order preserved.
//  5 FWFT=1: write 0xA5 to empty -> next cycle rd_valid=1, rd_data=0xA5 with no rd_en;
//    rd_en=1 -> next cycle empty=1, rd_valid=0.
//  6 Runtime thresholds: count=5, af_thresh 6->5 -> almost_full rises in the same cycle;
//    ae_thresh=5 -> almost_empty=1; count 6 -> almost_empty=0.

Source files
------------

// File: rtl/configurable_mode_fifo.sv
// Single-clock FIFO with registered or first-word-fall-through read, runtime
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module configurable_mode_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int FWFT       = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  input  logic [ADDR_WIDTH:0]   i_af_thresh,
  input  logic [ADDR_WIDTH:0]   i_ae_thresh,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wrPtr;
  logic [ADDR_WIDTH-1:0] r_rdPtr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wrAcc;
  logic w_rdAcc;
  logic w_wrReject;
  logic w_rdReject;

  // Full is decoded from the registered count, so a same-cycle read cannot make room for a write.
  assign w_full     = (r_count == FULL_COUNT);
  assign w_empty    = (r_count == '0);
  assign w_wrAcc    = i_wr_en & ~w_full & ~i_flush;
  assign w_rdAcc    = i_rd_en & ~w_empty & ~i_flush;
  assign w_wrReject = i_wr_en & w_full & ~i_flush;
  assign w_rdReject = i_rd_en & w_empty & ~i_flush;

  assign o_count        = r_count;
  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (r_count >= i_af_thresh);
  assign o_almost_empty = (r_count <= i_ae_thresh);
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

  always_ff @(posedge i_clk) begin
    if (w_wrAcc) begin
      r_mem[r_wrPtr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_flush) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wrAcc) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_rdAcc) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_wrAcc, w_rdAcc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_wrReject) begin
        r_overflow <= 1'b1;
      end
      if (w_rdReject) begin
        r_underflow <= 1'b1;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign o_rd_data  = r_mem[r_rdPtr];
      assign o_rd_valid = ~w_empty;
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] r_rdData;
      logic                  r_rdValid;

      // rd_data is deliberately left untouched by flush so downstream still sees the last word.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_rdData  <= '0;
          r_rdValid <= 1'b0;
        end else if (i_flush) begin
          r_rdValid <= 1'b0;
        end else begin
          r_rdValid <= w_rdAcc;
          if (w_rdAcc) begin
            r_rdData <= r_mem[r_rdPtr];
          end
        end
      end

      assign o_rd_data  = r_rdData;
      assign o_rd_valid = r_rdValid;
    end
  endgenerate

endmodule
